// File: rtl/key_cmd_pkg.sv
// Shared types for the key command front-end: command ids and arbiter states.
package key_cmd_pkg;

   typedef enum logic [1:0] {
      CMD_PAGE_WR = 2'd0,
      CMD_PAGE_RD = 2'd1,
      CMD_AUX     = 2'd2
   } cmd_id_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchroniser, stability counter, stable level
// register and a one-cycle event pulse on the selected debounced edge.
// Build option: KEY_RELEASE_TRIG_EN selects the release (0->1) edge as the
// event instead of the press (1->0) edge.
module key_debounce #(
   parameter int CNT_MAX = 999
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level,
   output logic evt
);

   localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

`ifdef KEY_RELEASE_TRIG_EN
   localparam logic TRIG_LVL = 1'b1;
`else
   localparam logic TRIG_LVL = 1'b0;
`endif

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;
   logic             settle;

   // Level has differed for CNT_MAX+1 consecutive cycles.
   assign settle = (sync_2 != level) && (cnt == CNT_W'(CNT_MAX));

   // Two-flop synchroniser, released (1) out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key_raw;
         sync_2 <= sync_1;
      end
   end

   // Stability counter; clears on agreement or on acceptance, so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if ((sync_2 == level) || settle) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Stable level update and matching edge pulse on the same clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b1;
         evt   <= 1'b0;
      end else begin
         if (settle) level <= sync_2;
         evt <= settle && (sync_2 == TRIG_LVL);
      end
   end

endmodule

// File: rtl/key_cmd_gen.sv
// Key command generator: debounces KEY_NUM active-low buttons and issues one
// command per debounced event on a valid/ready handshake, lowest key first.
// Each key can queue one further event behind the command in flight.
// Build option: KEY_RELEASE_TRIG_EN (see key_debounce) triggers on release.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no command offered; grants lowest pending key when any set
//   ST_HOLD | cmd_valid high, cmd_id frozen until cmd_ready is seen
module key_cmd_gen
   import key_cmd_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int KEY_NUM     = 3,
   localparam int ID_W       = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_NUM-1:0] key,
   output logic               cmd_valid,
   output logic [ID_W-1:0]    cmd_id,
   input  logic               cmd_ready,
   output logic [KEY_NUM-1:0] key_level
);

   localparam int CNT_MAX = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS - 1;

   logic [KEY_NUM-1:0] evt;
   logic [KEY_NUM-1:0] pending;
   logic [KEY_NUM-1:0] clr;
   logic               grant_any;
   logic [ID_W-1:0]    grant_idx;
   logic               take;
   arb_state_e         state;
   arb_state_e         state_nxt;

   for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
      key_debounce #(
         .CNT_MAX (CNT_MAX)
      ) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .key_raw (key[g]),
         .level   (key_level[g]),
         .evt     (evt[g])
      );
   end

   // Lowest-index pending key wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = KEY_NUM - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end

   // One-hot clear of the granted pending bit.
   always_comb begin
      clr = '0;
      for (int i = 0; i < KEY_NUM; i++) begin
         clr[i] = take && (grant_idx == ID_W'(i));
      end
   end

   // Pending flags; a new event in the same cycle as its grant keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~clr) | evt;
   end

   // Arbiter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Arbiter next-state and grant strobe.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_any) begin
               take      = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cmd_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command id latched at grant, held through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cmd_id <= '0;
      else if (take) cmd_id <= grant_idx;
   end

   assign cmd_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_key_cmd_gen.sv
// Directed bench for key_cmd_gen with CNT_MAX = 999 (50 kHz clock, 20 ms).
// Edge numbering: inputs change at a negedge just after "edge 0"; outputs are
// sampled at the negedge following each numbered rising edge.
module tb_key_cmd_gen;
   import key_cmd_pkg::*;

   localparam int NEVER = 1_000_000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] key;
   logic       cmd_valid;
   logic [1:0] cmd_id;
   logic       cmd_ready;
   logic [2:0] key_level;

   int n_chk  = 0;
   int n_pass = 0;

   int         cyc;
   int         first_v;
   int         first_lvl;
   int         n_v;
   int         n_acc;
   int         acc_id  [8];
   int         acc_cyc [8];
   int         unstable;
   logic [2:0] lvl_snap;

   key_cmd_gen #(
      .CLK_FREQ_HZ (50_000),
      .DEBOUNCE_MS (20),
      .KEY_NUM     (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key),
      .cmd_valid (cmd_valid),
      .cmd_id    (cmd_id),
      .cmd_ready (cmd_ready),
      .key_level (key_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic clr_stats();
      cyc       = 0;
      first_v   = -1;
      first_lvl = -1;
      n_v       = 0;
      n_acc     = 0;
      unstable  = 0;
      lvl_snap  = key_level;
      for (int i = 0; i < 8; i++) begin
         acc_id[i]  = -1;
         acc_cyc[i] = -1;
      end
   endtask

   // Run n cycles; cmd_ready is high for edges numbered >= ready_on.
   task automatic watch(input int n, input int ready_on);
      logic       held;
      logic [1:0] hold_id;
      held    = cmd_valid;
      hold_id = cmd_id;
      for (int k = 0; k < n; k++) begin
         cyc++;
         cmd_ready = (cyc >= ready_on);
         if (cmd_valid && cmd_ready) begin
            if (n_acc < 8) begin
               acc_id[n_acc]  = int'(cmd_id);
               acc_cyc[n_acc] = cyc;
            end
            n_acc++;
            held = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (cmd_valid) begin
            n_v++;
            if (first_v < 0) first_v = cyc;
            if (held && cmd_id != hold_id) unstable++;
            held    = 1'b1;
            hold_id = cmd_id;
         end else begin
            held = 1'b0;
         end
         if (first_lvl < 0 && key_level != lvl_snap) first_lvl = cyc;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      key       = 3'b111;
      cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_id", int'(cmd_id), 0);
      chk("rst_level", int'(key_level), 7);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

`ifdef KEY_RELEASE_TRIG_EN
      clr_stats();
      key[0] = 1'b0;
      watch(1100, 0);
      chk("rel_press_no_cmd", n_v, 0);
      chk("rel_press_lvl_edge", first_lvl, 1002);
      clr_stats();
      key[0] = 1'b1;
      watch(1100, 0);
      chk("rel_lvl_edge", first_lvl, 1002);
      chk("rel_valid_edge", first_v, 1004);
      chk("rel_valid_cycles", n_v, 1);
      chk("rel_id", acc_id[0], int'(CMD_PAGE_WR));
      clr_stats();
      key[2] = 1'b0;
      watch(1100, 0);
      key[2] = 1'b1;
      watch(1100, 0);
      chk("rel_k2_count", n_acc, 1);
      chk("rel_k2_id", acc_id[0], int'(CMD_AUX));
      chk("rel_k2_edge", acc_cyc[0], 2105);
`else
      // Clean press and release of key[0].
      clr_stats();
      key[0] = 1'b0;
      watch(1010, 0);
      chk("press_lvl_edge", first_lvl, 1002);
      chk("press_valid_edge", first_v, 1004);
      chk("press_valid_cycles", n_v, 1);
      chk("press_id", acc_id[0], int'(CMD_PAGE_WR));
      clr_stats();
      key[0] = 1'b1;
      watch(1100, 0);
      chk("release_no_cmd", n_v, 0);
      chk("release_lvl_edge", first_lvl, 1002);

      // Bounce on key[1]: 300-cycle toggles never settle.
      clr_stats();
      for (int t = 0; t < 10; t++) begin
         key[1] = ~key[1];
         watch(300, 0);
      end
      watch(1200, 0);
      chk("bounce_no_cmd", n_v, 0);
      chk("bounce_no_lvl", first_lvl, -1);

      // Simultaneous press of key[2] and key[0], ready held off for 50 cycles.
      clr_stats();
      key = 3'b010;
      watch(1100, 1054);
      chk("sim_count", n_acc, 2);
      chk("sim_first_id", acc_id[0], int'(CMD_PAGE_WR));
      chk("sim_second_id", acc_id[1], int'(CMD_AUX));
      chk("sim_first_acc", acc_cyc[0], 1054);
      chk("sim_gap", acc_cyc[1] - acc_cyc[0], 2);
      chk("sim_id_stable", unstable, 0);
      chk("sim_valid_cycles", n_v, 51);
      key = 3'b111;
      watch(1100, 0);

      // Backpressure: requeue once during HOLD, third press is dropped.
      clr_stats();
      key[1] = 1'b0;
      watch(1010, NEVER);
      key[1] = 1'b1;
      watch(1100, NEVER);
      key[1] = 1'b0;
      watch(1100, NEVER);
      key[1] = 1'b1;
      watch(1100, NEVER);
      key[1] = 1'b0;
      watch(1100, NEVER);
      chk("bp_held_valid", int'(cmd_valid), 1);
      key[1] = 1'b1;
      watch(2000, cyc + 1);
      chk("bp_count", n_acc, 2);
      chk("bp_id0", acc_id[0], int'(CMD_PAGE_RD));
      chk("bp_id1", acc_id[1], int'(CMD_PAGE_RD));
      chk("bp_gap", acc_cyc[1] - acc_cyc[0], 2);
      chk("bp_id_stable", unstable, 0);

      // Reset during HOLD with key[0] held low through reset.
      clr_stats();
      key[0] = 1'b0;
      watch(1010, NEVER);
      chk("rst_hold_valid", int'(cmd_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", int'(cmd_valid), 0);
      chk("rst_async_level", int'(key_level), 7);
      chk("rst_async_id", int'(cmd_id), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_stats();
      watch(1100, 0);
      chk("rst_after_valid_edge", first_v, 1004);
      chk("rst_after_count", n_acc, 1);
      chk("rst_after_id", acc_id[0], int'(CMD_PAGE_WR));
      key[0] = 1'b1;
      watch(1100, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
